// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters beside the ID stage.
// Counts writes issued from ID and not yet retired or squashed, and raises
// stall when the instruction in IF/ID reads a register with a pending write.
module reg_scoreboard #(
    parameter int unsigned MAX_PEND  = 3,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_regWrite,
    input  logic [4:0]  issue_write_reg,
    input  logic        mem_wb_regWrite,
    input  logic [4:0]  mem_wb_write_reg,
    input  logic        kill_valid,
    input  logic [4:0]  kill_write_reg,
    input  logic [6:0]  if_id_opcode,
    input  logic [4:0]  if_id_read_reg1,
    input  logic [4:0]  if_id_read_reg2,
    output logic        stall,
    output logic [31:0] busy_vec,
    output logic        err_overflow,
    output logic        err_underflow
);

    localparam int unsigned CW    = $clog2(MAX_PEND + 1);
    localparam int          MAX_I = int'(MAX_PEND);

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef logic [CW-1:0] cnt_t;

    // x0 is never tracked, so only x1..x31 carry a counter
    cnt_t        count     [1:31];
    cnt_t        count_nxt [1:31];
    logic [31:0] ovf_hit;
    logic [31:0] unf_hit;
    logic [31:0] pending;
    logic        uses_rs1;
    logic        uses_rs2;
    int          net;

    // Signed net change per register (+issue -retire -kill), saturated to 0..MAX_PEND
    always_comb begin
        count_nxt = count;
        ovf_hit   = '0;
        unf_hit   = '0;
        net       = 0;
        for (int unsigned r = 1; r < 32; r++) begin
            net = int'(count[r])
                + ((issue_valid && issue_regWrite && issue_write_reg == 5'(r)) ? 1 : 0)
                - ((mem_wb_regWrite && mem_wb_write_reg == 5'(r)) ? 1 : 0)
                - ((kill_valid && kill_write_reg == 5'(r)) ? 1 : 0);
            if (net > MAX_I) begin
                count_nxt[r] = cnt_t'(MAX_PEND);
                ovf_hit[r]   = 1'b1;
            end else if (net < 0) begin
                count_nxt[r] = '0;
                unf_hit[r]   = 1'b1;
            end else begin
                count_nxt[r] = cnt_t'(net);
            end
        end
    end

    // Counter state, registered busy mirror and sticky error flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 1; r < 32; r++) begin
                count[r] <= '0;
            end
            busy_vec      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            for (int unsigned r = 1; r < 32; r++) begin
                count[r]    <= count_nxt[r];
                busy_vec[r] <= (count_nxt[r] != '0);
            end
            busy_vec[0]   <= 1'b0;
            err_overflow  <= err_overflow | (|ovf_hit);
            err_underflow <= err_underflow | (|unf_hit);
        end
    end

    // Effective pending: a lone write retiring this cycle is already resolved under bypass
    always_comb begin
        pending = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            pending[r] = (count[r] != '0)
                && !(WB_BYPASS && count[r] == cnt_t'(1)
                     && mem_wb_regWrite && mem_wb_write_reg == 5'(r));
        end
    end

    // Source-operand usage decoded from the ID-stage opcode
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (if_id_opcode)
            OP_R_TYPE, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_I_TYPE, OP_LOAD, OP_JALR: begin
                uses_rs1 = 1'b1;
            end
            default: ;
        endcase
    end

    // Stall when any used, non-zero source has an outstanding write
    always_comb begin
        stall = (uses_rs1 && if_id_read_reg1 != '0 && pending[if_id_read_reg1])
             || (uses_rs2 && if_id_read_reg2 != '0 && pending[if_id_read_reg2]);
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vectors for reg_scoreboard, checked every cycle
// against an integer-count model plus hand-computed literal expectations.
module tb_reg_scoreboard;

    localparam int unsigned MAX_PEND  = 3;
    localparam bit          WB_BYPASS = 1'b1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_regWrite;
    logic [4:0]  issue_write_reg;
    logic        mem_wb_regWrite;
    logic [4:0]  mem_wb_write_reg;
    logic        kill_valid;
    logic [4:0]  kill_write_reg;
    logic [6:0]  if_id_opcode;
    logic [4:0]  if_id_read_reg1;
    logic [4:0]  if_id_read_reg2;
    logic        stall;
    logic [31:0] busy_vec;
    logic        err_overflow;
    logic        err_underflow;

    int n_vec = 0;
    int n_err = 0;

    // model state: plain integer pending counts per register
    int mcnt [32];
    bit movf;
    bit munf;
    int d;

    reg_scoreboard #(
        .MAX_PEND  (MAX_PEND),
        .WB_BYPASS (WB_BYPASS)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_regWrite   (issue_regWrite),
        .issue_write_reg  (issue_write_reg),
        .mem_wb_regWrite  (mem_wb_regWrite),
        .mem_wb_write_reg (mem_wb_write_reg),
        .kill_valid       (kill_valid),
        .kill_write_reg   (kill_write_reg),
        .if_id_opcode     (if_id_opcode),
        .if_id_read_reg1  (if_id_read_reg1),
        .if_id_read_reg2  (if_id_read_reg2),
        .stall            (stall),
        .busy_vec         (busy_vec),
        .err_overflow     (err_overflow),
        .err_underflow    (err_underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {OP_R, OP_ST, OP_BR, OP_I, OP_LD, OP_JR};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {OP_R, OP_ST, OP_BR};
    endfunction

    function automatic bit m_pending(input int r);
        if (r == 0 || mcnt[r] == 0) return 1'b0;
        if (WB_BYPASS && mcnt[r] == 1 && mem_wb_regWrite && int'(mem_wb_write_reg) == r)
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_stall();
        return (reads_rs1(if_id_opcode) && m_pending(int'(if_id_read_reg1)))
            || (reads_rs2(if_id_opcode) && m_pending(int'(if_id_read_reg2)));
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] b = '0;
        for (int r = 1; r < 32; r++) b[r] = (mcnt[r] != 0);
        return b;
    endfunction

    // model update: count + issue - retire - kill, clipped to 0..MAX_PEND
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
            movf = 1'b0;
            munf = 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                d = mcnt[r];
                if (issue_valid && issue_regWrite && int'(issue_write_reg) == r) d = d + 1;
                if (mem_wb_regWrite && int'(mem_wb_write_reg) == r) d = d - 1;
                if (kill_valid && int'(kill_write_reg) == r) d = d - 1;
                if (d > int'(MAX_PEND)) begin d = int'(MAX_PEND); movf = 1'b1; end
                if (d < 0) begin d = 0; munf = 1'b1; end
                mcnt[r] = d;
            end
        end
    end

    // compare process: outputs against the model on every falling edge
    always @(negedge clock) begin
        check("stall",         32'(stall),         32'(exp_stall()));
        check("busy_vec",      busy_vec,           exp_busy());
        check("err_overflow",  32'(err_overflow),  32'(movf));
        check("err_underflow", 32'(err_underflow), 32'(munf));
    end

    task automatic idle();
        issue_valid      = 1'b0;
        issue_regWrite   = 1'b0;
        issue_write_reg  = '0;
        mem_wb_regWrite  = 1'b0;
        mem_wb_write_reg = '0;
        kill_valid       = 1'b0;
        kill_write_reg   = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd);
        issue_valid     = 1'b1;
        issue_regWrite  = 1'b1;
        issue_write_reg = rd;
    endtask

    task automatic do_retire(input logic [4:0] rd);
        mem_wb_regWrite  = 1'b1;
        mem_wb_write_reg = rd;
    endtask

    task automatic set_id(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2);
        if_id_opcode    = op;
        if_id_read_reg1 = r1;
        if_id_read_reg2 = r2;
    endtask

    logic [6:0] ops [8];

    initial begin
        ops[0] = OP_R;  ops[1] = OP_ST; ops[2] = OP_BR;  ops[3] = OP_I;
        ops[4] = OP_LD; ops[5] = OP_JR; ops[6] = OP_LUI; ops[7] = 7'b1111111;

        reset = 1'b0;
        idle();
        set_id(OP_LUI, 5'd0, 5'd0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy_vec, 32'h0);
        check("rst_stall", 32'(stall), 0);
        check("rst_ovf", 32'(err_overflow), 0);
        check("rst_unf", 32'(err_underflow), 0);
        reset = 1'b1;
        tick();
        check("rel_busy", busy_vec, 32'h0);

        // dependent pair on x1: two stall cycles, bypass clears on retire
        do_issue(5'd1);
        tick();
        idle();
        set_id(OP_R, 5'd1, 5'd3);
        #1;
        check("dep_stall_c1", 32'(stall), 1);
        tick();
        check("dep_stall_c2", 32'(stall), 1);
        check("dep_busy1", 32'(busy_vec[1]), 1);
        tick();
        do_retire(5'd1);
        #1;
        check("dep_bypass", 32'(stall), 0);
        tick();
        idle();
        set_id(OP_LUI, 5'd0, 5'd0);
        #1;
        check("dep_busy1_clr", 32'(busy_vec[1]), 0);

        // x5: three issues, two retires leave one pending
        for (int i = 0; i < 3; i++) begin
            do_issue(5'd5);
            tick();
        end
        idle();
        do_retire(5'd5);
        tick();
        tick();
        idle();
        #1;
        check("x5_busy", 32'(busy_vec[5]), 1);
        set_id(OP_BR, 5'd0, 5'd5);
        #1;
        check("x5_branch_stall", 32'(stall), 1);
        set_id(OP_LUI, 5'd0, 5'd5);
        #1;
        check("x5_lui_nostall", 32'(stall), 0);
        set_id(OP_BR, 5'd0, 5'd5);
        do_retire(5'd5);
        #1;
        check("x5_last_bypass", 32'(stall), 0);
        tick();
        idle();
        set_id(OP_LUI, 5'd0, 5'd0);
        #1;
        check("x5_busy_clr", 32'(busy_vec[5]), 0);

        // x10: issue+retire holds, retire+kill drops by two
        do_issue(5'd10);
        tick();
        do_issue(5'd10);
        do_retire(5'd10);
        tick();
        idle();
        #1;
        check("x10_hold", 32'(busy_vec[10]), 1);
        do_issue(5'd10);
        tick();
        idle();
        do_retire(5'd10);
        kill_valid     = 1'b1;
        kill_write_reg = 5'd10;
        tick();
        idle();
        #1;
        check("x10_cleared", 32'(busy_vec[10]), 0);
        check("x10_no_unf", 32'(err_underflow), 0);

        // x0 never tracked
        do_issue(5'd0);
        set_id(OP_I, 5'd0, 5'd0);
        #1;
        check("x0_stall", 32'(stall), 0);
        tick();
        idle();
        #1;
        check("x0_busy", busy_vec, 32'h0);
        check("x0_stall_after", 32'(stall), 0);

        // overflow on x7, underflow on x9, sticky until reset
        set_id(OP_LUI, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            do_issue(5'd7);
            tick();
        end
        idle();
        #1;
        check("x7_full_no_ovf", 32'(err_overflow), 0);
        do_issue(5'd7);
        tick();
        idle();
        #1;
        check("x7_ovf", 32'(err_overflow), 1);
        check("x7_busy", 32'(busy_vec[7]), 1);
        do_retire(5'd9);
        tick();
        idle();
        #1;
        check("x9_unf", 32'(err_underflow), 1);
        repeat (3) tick();
        check("ovf_sticky", 32'(err_overflow), 1);
        check("unf_sticky", 32'(err_underflow), 1);
        set_id(OP_R, 5'd7, 5'd0);
        #1;
        check("x7_stall", 32'(stall), 1);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_stall", 32'(stall), 0);
        check("async_rst_ovf", 32'(err_overflow), 0);
        check("async_rst_unf", 32'(err_underflow), 0);
        check("async_rst_busy", busy_vec, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_stall", 32'(stall), 0);

        // mixed traffic on x0..x7, model checks every cycle
        for (int i = 0; i < 80; i++) begin
            set_id(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            mem_wb_regWrite  = ($urandom_range(0, 2) == 0);
            mem_wb_write_reg = 5'($urandom_range(0, 7));
            kill_valid       = ($urandom_range(0, 5) == 0);
            kill_write_reg   = 5'($urandom_range(0, 7));
            issue_regWrite   = ($urandom_range(0, 3) != 0);
            issue_write_reg  = 5'($urandom_range(0, 7));
            #1;
            issue_valid = !stall && ($urandom_range(0, 1) == 1);
            tick();
        end
        idle();
        set_id(OP_JAL, 5'd0, 5'd0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
